// File: rtl/cpu_pkg.sv
// cpu_pkg: ALU opcodes, forward-select codes, multiplier FSM states and the forwarding mux helper
package cpu_pkg;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7,
                         ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11,
                         ALU_MUL = 4'd12;
  localparam logic [1:0] FWD_MEM = 2'b01, FWD_WB = 2'b10;
  typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_e;
  function automatic logic [31:0] fwd_sel(input logic [1:0] sel, input logic [31:0] rf, mem, wb);
    return sel == FWD_MEM ? mem : sel == FWD_WB ? wb : rf;
  endfunction
endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX inputs, forwarding sources and EX/MEM outputs of the execute stage
interface ex_stage_if;
  logic        ID_EX_valid;
  logic [3:0]  ID_EX_ALUOp;
  logic        ID_EX_ALUSrc;
  logic [31:0] ID_EX_Imm;
  logic [31:0] ID_EX_RsData;
  logic [31:0] ID_EX_RtData;
  logic [4:0]  ID_EX_WriteReg;
  logic        ID_EX_RegWrite;
  logic        ID_EX_MemRead;
  logic        ID_EX_MemWrite;
  logic        ID_EX_MemToReg;
  logic [1:0]  ForwardA;
  logic [1:0]  ForwardB;
  logic [31:0] MEM_FwdData;
  logic [31:0] WB_FwdData;
  logic        EX_flush;
  logic        EX_stall;
  logic        EX_MEM_valid;
  logic        EX_MEM_RegWrite;
  logic        EX_MEM_MemRead;
  logic        EX_MEM_MemWrite;
  logic        EX_MEM_MemToReg;
  logic [31:0] EX_MEM_ALU_Z;
  logic [31:0] EX_MEM_RdData;
  logic [4:0]  EX_MEM_WriteReg;
  modport slave (
    input  ID_EX_valid, ID_EX_ALUOp, ID_EX_ALUSrc, ID_EX_Imm, ID_EX_RsData, ID_EX_RtData,
           ID_EX_WriteReg, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg,
           ForwardA, ForwardB, MEM_FwdData, WB_FwdData, EX_flush,
    output EX_stall, EX_MEM_valid, EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite,
           EX_MEM_MemToReg, EX_MEM_ALU_Z, EX_MEM_RdData, EX_MEM_WriteReg
  );
  modport master (
    output ID_EX_valid, ID_EX_ALUOp, ID_EX_ALUSrc, ID_EX_Imm, ID_EX_RsData, ID_EX_RtData,
           ID_EX_WriteReg, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg,
           ForwardA, ForwardB, MEM_FwdData, WB_FwdData, EX_flush,
    input  EX_stall, EX_MEM_valid, EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite,
           EX_MEM_MemToReg, EX_MEM_ALU_Z, EX_MEM_RdData, EX_MEM_WriteReg
  );
endinterface

// File: rtl/ex_seq_mul.sv
// ex_seq_mul: iterative shift-add multiplier retiring K multiplier bits per cycle; busy covers the start cycle
module ex_seq_mul
  import cpu_pkg::*;
#(
  parameter int K = 1
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);
  localparam int N = 32 / K;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  mul_state_e state, state_nxt;
  logic [31:0] a, b, acc;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state <= MUL_IDLE;
      a     <= '0;
      b     <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == MUL_IDLE && start) begin
        a   <= op_a;
        b   <= op_b;
        acc <= '0;
        cnt <= CW'(N - 1);
      end else if (state == MUL_BUSY) begin
        acc <= acc + 32'(a * 32'(b[K-1:0]));
        a   <= a << K;
        b   <= b >> K;
        cnt <= cnt - 1'b1;
      end
    end
  end
  always_comb begin
    state_nxt = state;
    state_nxt = flush ? MUL_IDLE :
                state == MUL_IDLE ? (start ? MUL_BUSY : MUL_IDLE) :
                state == MUL_BUSY ? (cnt == '0 ? MUL_DONE : MUL_BUSY) : MUL_IDLE;
  end
  assign busy    = !flush && ((state == MUL_IDLE && start) || state == MUL_BUSY);
  assign done    = state == MUL_DONE;
  assign product = acc;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: operand forwarding, ALU, sequential multiplier hookup and the EX/MEM pipeline register
module ex_stage
  import cpu_pkg::*;
#(
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input logic       clk,
  input logic       reset_b,
  ex_stage_if.slave bus
);
  logic [31:0] op_a, fwd_b, op_b, alu_z, product;
  logic mul_start, mul_busy, mul_done, load;
  assign op_a  = fwd_sel(bus.ForwardA, bus.ID_EX_RsData, bus.MEM_FwdData, bus.WB_FwdData);
  assign fwd_b = fwd_sel(bus.ForwardB, bus.ID_EX_RtData, bus.MEM_FwdData, bus.WB_FwdData);
  assign op_b  = bus.ID_EX_ALUSrc ? bus.ID_EX_Imm : fwd_b;
  always_comb begin
    alu_z = '0;
    case (bus.ID_EX_ALUOp)
      ALU_ADD:  alu_z = op_a + op_b;
      ALU_SUB:  alu_z = op_a - op_b;
      ALU_AND:  alu_z = op_a & op_b;
      ALU_OR:   alu_z = op_a | op_b;
      ALU_XOR:  alu_z = op_a ^ op_b;
      ALU_NOR:  alu_z = ~(op_a | op_b);
      ALU_SLT:  alu_z = {31'b0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_z = {31'b0, op_a < op_b};
      ALU_SLL:  alu_z = op_b << op_a[4:0];
      ALU_SRL:  alu_z = op_b >> op_a[4:0];
      ALU_SRA:  alu_z = $signed(op_b) >>> op_a[4:0];
      ALU_LUI:  alu_z = {op_b[15:0], 16'h0};
      default:  alu_z = '0;
    endcase
  end
  assign mul_start = bus.ID_EX_valid && bus.ID_EX_ALUOp == ALU_MUL && !bus.EX_flush;
  ex_seq_mul #(.K(MUL_BITS_PER_CYCLE)) u_mul (
    .clk     (clk),
    .reset_b (reset_b),
    .start   (mul_start),
    .flush   (bus.EX_flush),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );
  // Stall is combinational from ID/EX, so hold it low while reset is asserted
  assign bus.EX_stall = reset_b && mul_busy;
  assign load = bus.ID_EX_valid && !bus.EX_flush && !mul_busy;
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      bus.EX_MEM_valid    <= 1'b0;
      bus.EX_MEM_RegWrite <= 1'b0;
      bus.EX_MEM_MemRead  <= 1'b0;
      bus.EX_MEM_MemWrite <= 1'b0;
      bus.EX_MEM_MemToReg <= 1'b0;
      bus.EX_MEM_ALU_Z    <= '0;
      bus.EX_MEM_RdData   <= '0;
      bus.EX_MEM_WriteReg <= '0;
    end else begin
      bus.EX_MEM_valid    <= load;
      bus.EX_MEM_RegWrite <= load && bus.ID_EX_RegWrite;
      bus.EX_MEM_MemRead  <= load && bus.ID_EX_MemRead;
      bus.EX_MEM_MemWrite <= load && bus.ID_EX_MemWrite;
      if (load) begin
        bus.EX_MEM_MemToReg <= bus.ID_EX_MemToReg;
        bus.EX_MEM_ALU_Z    <= mul_done ? product : alu_z;
        bus.EX_MEM_RdData   <= fwd_b;
        bus.EX_MEM_WriteReg <= bus.ID_EX_WriteReg;
      end
    end
  end
endmodule
